// File: rtl/egress_header_rewrite.sv
`default_nettype none
// ============================================================================
// Module   : egress_header_rewrite
// Purpose  : Transmit-side header rewrite for the router output-port-lookup
//            pipeline. For packets leaving on a physical port, it rewrites
//            the Ethernet dst/src MACs. For IPv4 packets it also decrements
//            the TTL and incrementally updates the IP header checksum.
//            Packets whose TTL has expired are dropped. Packets bound for a
//            CPU port pass through untouched.
// Ports    : AXI_ACLK/AXI_RESETN        clock, async active-low reset
//            S_AXIS_*                   ingress stream (buffered in a FIFO)
//            M_AXIS_*                   egress stream (single register slice)
//            reset                      counter clear when equal to 1
//            macN_low/macN_high         per-port source MAC configuration
//            tx_count/ttl_drop_count    forwarded / TTL-dropped packet counts
// Revision : 1.0 - initial release
// ============================================================================
module egress_header_rewrite #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS         = 24,
  parameter int NH_MAC_POS           = 32
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic                                S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic                                M_AXIS_TLAST,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       reset,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac0_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac0_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac1_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac1_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac2_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac2_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac3_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       mac3_high,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       tx_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       ttl_drop_count
);

  localparam int DW         = C_S_AXIS_DATA_WIDTH;
  localparam int UW         = C_S_AXIS_TUSER_WIDTH;
  localparam int SW         = C_S_AXIS_DATA_WIDTH / 8;
  localparam int FIFO_WIDTH = DW + UW + SW + 1;
  localparam int FIFO_AW    = 4;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] ST_HEADER  = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;

  // ---------------------------------------------------------------- input FIFO
  // Show-ahead FIFO: the head entry is visible whenever the FIFO is not empty.
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]      count_q, count_d;
  logic                  w_push, w_pop, w_empty;
  logic [FIFO_WIDTH-1:0] w_rd_word;
  logic [DW-1:0]         w_rd_data;
  logic [UW-1:0]         w_rd_user;
  logic [SW-1:0]         w_rd_strb;
  logic                  w_rd_last;

  // Nearly-full leaves one slot of slack so ready can be deasserted early.
  assign S_AXIS_TREADY = (count_q < 5'(FIFO_DEPTH - 1));
  assign w_push        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_empty       = (count_q == '0);

  assign w_rd_word = mem_q[rd_ptr_q];
  assign w_rd_data = w_rd_word[DW-1:0];
  assign w_rd_user = w_rd_word[DW +: UW];
  assign w_rd_strb = w_rd_word[DW+UW +: SW];
  assign w_rd_last = w_rd_word[FIFO_WIDTH-1];

  always_ff @(posedge AXI_ACLK) begin
    if (w_push) mem_q[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TDATA};
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 4'd1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 4'd1;
      count_q <= count_d;
    end
  end

  // ------------------------------------------------------ header rewrite path
  logic [1:0]    state_q, state_d;
  logic          w_phys_hit;
  logic [47:0]   w_port_mac;
  logic [DW-1:0] w_hdr_data;
  logic          w_hdr_drop;
  logic [16:0]   w_ck_sum;
  logic [15:0]   w_ck_new;
  logic          w_unused_mac_bits;

  assign w_unused_mac_bits = ^{mac0_high[C_S_AXI_DATA_WIDTH-1:16], mac1_high[C_S_AXI_DATA_WIDTH-1:16],
                               mac2_high[C_S_AXI_DATA_WIDTH-1:16], mac3_high[C_S_AXI_DATA_WIDTH-1:16]};

  // Lowest-numbered physical port wins when several dst-port bits are set.
  always_comb begin
    w_phys_hit = 1'b1;
    w_port_mac = 48'h0;
    if (w_rd_user[DST_PORT_POS])          w_port_mac = {mac0_high[15:0], mac0_low[31:0]};
    else if (w_rd_user[DST_PORT_POS + 2]) w_port_mac = {mac1_high[15:0], mac1_low[31:0]};
    else if (w_rd_user[DST_PORT_POS + 4]) w_port_mac = {mac2_high[15:0], mac2_low[31:0]};
    else if (w_rd_user[DST_PORT_POS + 6]) w_port_mac = {mac3_high[15:0], mac3_low[31:0]};
    else                                  w_phys_hit = 1'b0;
  end

  // TTL drops by one, so the checksum rises by 0x0100 with end-around carry.
  assign w_ck_sum = {1'b0, w_rd_data[63:48]} + 17'h00100;
  assign w_ck_new = w_ck_sum[15:0] + {15'd0, w_ck_sum[16]};

  always_comb begin
    w_hdr_data = w_rd_data;
    w_hdr_drop = 1'b0;
    if (w_phys_hit) begin
      w_hdr_data[255:208] = w_rd_user[NH_MAC_POS +: 48];
      w_hdr_data[207:160] = w_port_mac;
      if (w_rd_data[159:144] == 16'h0800) begin
        if (w_rd_data[79:72] <= 8'd1) begin
          w_hdr_drop = 1'b1;
        end else begin
          w_hdr_data[79:72] = w_rd_data[79:72] - 8'd1;
          w_hdr_data[63:48] = w_ck_new;
        end
      end
    end
  end

  // ------------------------------------------------------------ control FSM
  logic          w_keep, w_first, w_ttl_drop;
  logic [DW-1:0] w_out_data;

  // DROP drains the FIFO even while the output register is stalled.
  assign w_pop = !w_empty && (!M_AXIS_TVALID || M_AXIS_TREADY || state_q == ST_DROP);

  always_comb begin
    state_d    = state_q;
    w_keep     = 1'b0;
    w_first    = 1'b0;
    w_ttl_drop = 1'b0;
    w_out_data = w_rd_data;
    if (w_pop) begin
      case (state_q)
        ST_HEADER: begin
          if (w_hdr_drop) begin
            w_ttl_drop = 1'b1;
            state_d    = w_rd_last ? ST_HEADER : ST_DROP;
          end else begin
            w_keep     = 1'b1;
            w_first    = 1'b1;
            w_out_data = w_hdr_data;
            state_d    = w_rd_last ? ST_HEADER : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          w_keep = 1'b1;
          if (w_rd_last) state_d = ST_HEADER;
        end
        ST_DROP: begin
          if (w_rd_last) state_d = ST_HEADER;
        end
        default: state_d = ST_HEADER;
      endcase
    end
  end

  // --------------------------------------------------- output register slice
  logic [C_M_AXIS_DATA_WIDTH-1:0]   m_data_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_strb_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  m_user_q;
  logic                             m_last_q, m_valid_q, m_valid_d;

  always_comb begin
    m_valid_d = m_valid_q;
    if (w_keep)             m_valid_d = 1'b1;
    else if (M_AXIS_TREADY) m_valid_d = 1'b0;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q   <= ST_HEADER;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_strb_q  <= '0;
      m_user_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      if (w_keep) begin
        m_data_q <= w_out_data;
        m_strb_q <= w_rd_strb;
        m_user_q <= w_rd_user;
        m_last_q <= w_rd_last;
      end
    end
  end

  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TSTRB  = m_strb_q;
  assign M_AXIS_TUSER  = m_user_q;
  assign M_AXIS_TLAST  = m_last_q;

  // ---------------------------------------------------------------- counters
  // A clear request outranks an increment in the same cycle.
  logic [C_S_AXI_DATA_WIDTH-1:0] tx_count_q, tx_count_d, drop_count_q, drop_count_d;
  logic                          w_clear;

  assign w_clear = (reset == C_S_AXI_DATA_WIDTH'(1));

  always_comb begin
    tx_count_d   = tx_count_q;
    drop_count_d = drop_count_q;
    if (w_clear) begin
      tx_count_d   = '0;
      drop_count_d = '0;
    end else begin
      if (w_first)    tx_count_d   = tx_count_q + 1'b1;
      if (w_ttl_drop) drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      tx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      tx_count_q   <= tx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign tx_count       = tx_count_q;
  assign ttl_drop_count = drop_count_q;

endmodule
`default_nettype wire
